// File: rtl/tl_rr_arbiter.sv
// tl_rr_arbiter: N-master TileLink Channel A / Channel C request arbiter.
// Channel C outranks Channel A. Each channel keeps its own round-robin
// pointer. Once a master is granted, the grant is held until that master's
// last beat is accepted. Every message is followed by one idle bubble cycle.
// Optional anti-starvation for Channel A is enabled by defining the macro
// TIDC_ARB_STARVE_EN. Without it, C strictly outranks A.
module tl_rr_arbiter #(
  parameter int NUM_MASTERS  = 4,
  parameter int ID_W         = $clog2(NUM_MASTERS),
  parameter int STARVE_LIMIT = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NUM_MASTERS-1:0]   a_valid_i,
  input  logic [3*NUM_MASTERS-1:0] a_opcode_i,
  input  logic [NUM_MASTERS-1:0]   a_last_i,
  output logic [NUM_MASTERS-1:0]   a_ready_o,
  input  logic [NUM_MASTERS-1:0]   c_valid_i,
  input  logic [3*NUM_MASTERS-1:0] c_opcode_i,
  input  logic [NUM_MASTERS-1:0]   c_last_i,
  output logic [NUM_MASTERS-1:0]   c_ready_o,
  output logic                     arb_valid,
  output logic [1:0]               arb_channel,
  output logic [ID_W-1:0]          arb_master_id,
  output logic [NUM_MASTERS-1:0]   arb_master_oh,
  output logic [2:0]               arb_opcode,
  output logic                     arb_beat,
  input  logic                     arb_ready,
  output logic                     arb_busy
);

  if (NUM_MASTERS < 2 || STARVE_LIMIT < 1 || STARVE_LIMIT > 255) begin : g_param_err
    $error("tl_rr_arbiter: illegal parameter value");
  end

  typedef enum logic {S_IDLE, S_LOCKED} state_e;

  state_e                 state_q;
  logic                   chan_q;      // 0 = A, 1 = C
  logic [ID_W-1:0]        id_q;
  logic [NUM_MASTERS-1:0] oh_q;
  logic [ID_W-1:0]        ptr_a_q;
  logic [ID_W-1:0]        ptr_c_q;

  logic                   any_a;
  logic                   any_c;
  logic                   pick_c;
  logic [ID_W-1:0]        grant_id;
  logic                   locked;
  logic                   sel_valid;
  logic                   sel_last;
  logic                   accept;

  logic [2:0] a_op [NUM_MASTERS];
  logic [2:0] c_op [NUM_MASTERS];

  for (genvar g = 0; g < NUM_MASTERS; g++) begin : g_op
    assign a_op[g] = a_opcode_i[3*g +: 3];
    assign c_op[g] = c_opcode_i[3*g +: 3];
  end

  // First requester found scanning upward from ptr+1, wrapping modulo N.
  function automatic logic [ID_W-1:0] rr_pick(input logic [NUM_MASTERS-1:0] req,
                                              input logic [ID_W-1:0]        ptr);
    logic [ID_W-1:0] sel;
    logic            found;
    int              idx;
    sel   = '0;
    found = 1'b0;
    for (int k = 1; k <= NUM_MASTERS; k++) begin
      idx = (int'(ptr) + k) % NUM_MASTERS;
      if (!found && req[idx]) begin
        sel   = ID_W'(idx);
        found = 1'b1;
      end
    end
    return sel;
  endfunction

  assign any_a = |a_valid_i;
  assign any_c = |c_valid_i;

`ifdef TIDC_ARB_STARVE_EN
  logic [7:0] starve_q;
  logic [7:0] starve_d;
  logic       force_a;

  assign force_a = (starve_q == 8'(STARVE_LIMIT)) && any_a;
  assign pick_c  = any_c && !force_a;

  // Starvation counter: counts C grants made while A waits, saturating; any A grant clears it.
  always_comb begin
    starve_d = starve_q;
    if (state_q == S_IDLE && (any_a || any_c)) begin
      if (!pick_c) begin
        starve_d = '0;
      end else if (any_a && starve_q < 8'(STARVE_LIMIT)) begin
        starve_d = starve_q + 8'd1;
      end
    end
  end

  // Starvation counter register.
  always_ff @(posedge clk) begin
    if (!rst_n) starve_q <= '0;
    else        starve_q <= starve_d;
  end
`else
  assign pick_c = any_c;
`endif

  assign grant_id = pick_c ? rr_pick(c_valid_i, ptr_c_q) : rr_pick(a_valid_i, ptr_a_q);

  assign locked    = (state_q == S_LOCKED);
  assign sel_valid = chan_q ? c_valid_i[id_q] : a_valid_i[id_q];
  assign sel_last  = chan_q ? c_last_i[id_q]  : a_last_i[id_q];
  assign arb_beat  = locked && sel_valid;
  assign accept    = arb_beat && arb_ready;

  // oh_q is zero outside LOCKED, so the ready vectors need no extra state gating.
  assign a_ready_o = (accept && !chan_q) ? oh_q : '0;
  assign c_ready_o = (accept &&  chan_q) ? oh_q : '0;

  assign arb_valid     = locked;
  assign arb_busy      = locked;
  assign arb_channel   = {1'b0, chan_q};
  assign arb_master_id = id_q;
  assign arb_master_oh = oh_q;
  assign arb_opcode    = chan_q ? c_op[id_q] : a_op[id_q];

  // Grant FSM: arbitrate in IDLE, hold the grant until the last beat is accepted.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      chan_q  <= 1'b0;
      id_q    <= '0;
      oh_q    <= '0;
      ptr_a_q <= ID_W'(NUM_MASTERS - 1);
      ptr_c_q <= ID_W'(NUM_MASTERS - 1);
    end else begin
      case (state_q)
        S_IDLE: begin
          if (any_a || any_c) begin
            state_q <= S_LOCKED;
            chan_q  <= pick_c;
            id_q    <= grant_id;
            oh_q    <= NUM_MASTERS'(1) << grant_id;
          end
        end
        S_LOCKED: begin
          if (accept && sel_last) begin
            state_q <= S_IDLE;
            oh_q    <= '0;
            if (chan_q) ptr_c_q <= id_q;
            else        ptr_a_q <= id_q;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule

// File: doc/tl_rr_arbiter.md
# tl_rr_arbiter

Parametrised N-master TileLink request arbiter for the TIDC directory front end. It selects one master's Channel A or Channel C request and locks the grant for the whole multi-beat message. Round-robin order is kept separately for each channel, and Channel C has priority over Channel A. It sits between the L1 master ports and the directory/L2 request pipeline, replacing the fixed 2-master arbiter.

## Interface
Parameters:
- NUM_MASTERS, 4: number of L1 masters (≥2).
- ID_W, $clog2(NUM_MASTERS): master index width.
- STARVE_LIMIT, 8: consecutive C grants with A pending before A is forced. Used only with the macro; range 1..255.

Ports:
- clk  in  1  system clock, all logic on rising edge.
- rst_n  in  1  reset, synchronous, active-low.
- a_valid_i  in  NUM_MASTERS  Channel A valid per master.
- a_opcode_i  in  3*NUM_MASTERS  packed A opcodes; master i is bits [3i+2:3i].
- a_last_i  in  NUM_MASTERS  current A beat is the final beat of the message.
- a_ready_o  out  NUM_MASTERS  Channel A beat accepted.
- c_valid_i, c_opcode_i, c_last_i, c_ready_o: same as the A ports, for Channel C.
- arb_valid  out  1  grant active.
- arb_channel  out  2  2'b00 = A, 2'b01 = C.
- arb_master_id  out  ID_W  granted master.
- arb_master_oh  out  NUM_MASTERS  one-hot of arb_master_id; all zero when arb_valid=0.
- arb_opcode  out  3  opcode of the granted master/channel, muxed combinationally.
- arb_beat  out  1  granted master's valid is high this cycle (a beat is presented).
- arb_ready  in  1  downstream accepts the current beat.
- arb_busy  out  1  state ≠ IDLE.

## Operation
- FSM has two states: IDLE and LOCKED.
- **IDLE:**
  - If any c_valid_i is high, the channel is C; otherwise, if any a_valid_i is high, the channel is A.
  - The master is the first requester found by scanning upward from ptr_ch+1 modulo NUM_MASTERS.
  - Channel, master id and one-hot are registered, and the FSM moves to LOCKED.
- **LOCKED:**
  - arb_valid=1. Channel and master are frozen. New requests from other masters or channels are ignored.
  - arb_beat = selected channel's valid[arb_master_id].
  - ready_o[arb_master_id] of the selected channel = arb_ready & arb_beat. All other ready bits are 0.
  - A beat with last[arb_master_id]=1 accepted: ptr_ch ← arb_master_id, FSM returns to IDLE.
  - Any other accepted beat: the FSM stays in LOCKED.
  - If the granted valid drops mid-message, the lock is held and no ready is issued.
- The A pointer and the C pointer update independently. The other channel's pointer is untouched.
- Both pointers reset to NUM_MASTERS-1, so master 0 wins first.
- Single-beat messages assert last on their only beat.

## Timing
- Reset values: arb_valid=0, arb_channel=2'b00, arb_master_id=0, arb_master_oh=0, arb_busy=0, all ready_o=0, FSM=IDLE, pointers=NUM_MASTERS-1, starvation counter=0.
- A request seen in IDLE at cycle t gives arb_valid=1 at t+1. The first beat can be accepted at t+1.
- After the last beat is accepted at cycle t, the block is in IDLE at t+1 and the next grant is visible at t+2. There is one bubble per message.
- ready_o is combinational from arb_ready and the valid inputs. There is no combinational path from valid to arb_valid.
- If rst_n is low on any edge, including mid-message, state returns to reset values on that edge. No partial message is completed.
- With a single requester, the round-robin scan returns that same master.

## Configuration
- TIDC_ARB_STARVE_EN defined:
  - An 8-bit counter increments on every C grant made while any a_valid_i is high.
  - When the counter reaches STARVE_LIMIT, the next IDLE arbitration with any A valid picks A, even if C is pending.
  - The counter clears on any A grant.
  - The counter saturates at STARVE_LIMIT.
- TIDC_ARB_STARVE_EN undefined:
  - Strict C>A priority. A can starve indefinitely.
  - The counter logic is absent.

## Test plan
- Reset, then a_valid_i=4'b0101 with single-beat messages and arb_ready=1 -> grants to masters 0, 2, 0, 2. arb_valid rises one cycle after valid. There is one bubble between grants.
- c_valid_i[3]=1 and a_valid_i[1]=1 together -> C to master 3 first (arb_channel=01, arb_master_oh=4'b1000), then A to master 1.
- Master 2 sends a 4-beat C burst with arb_ready toggling 1,0,1,1,1 while master 0 requests A -> c_ready_o[2] pulses exactly 4 times. The grant never switches before the 4th beat, which has last=1.
- Macro defined, STARVE_LIMIT=3, C valid continuously from masters 0 and 1, a_valid_i[3]=1 -> three C grants, then A to master 3, then C resumes. Macro undefined -> A is never granted.
- rst_n driven low for one cycle during beat 2 of a burst -> all outputs return to reset values on the next edge. After the next request, master 0 is granted first again.
